// File: rtl/lcd_tx_arbiter.sv
// rtl/lcd_tx_arbiter.sv - packet-atomic round-robin arbiter for the LCD FIFO write port
// A grant is held until a last-flagged word transfers or the stall watchdog expires.
module lcd_tx_arbiter #(
  parameter int NUM_REQ        = 3,
  parameter int WORD_WIDTH     = 9,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                                            clk,
  input  logic                                            rst,
  input  logic [NUM_REQ-1:0]                              req_valid,
  input  logic [NUM_REQ*WORD_WIDTH-1:0]                   req_data,
  input  logic [NUM_REQ-1:0]                              req_last,
  output logic [NUM_REQ-1:0]                              req_ready,
  output logic [NUM_REQ-1:0]                              grant,
  output logic                                            out_valid,
  output logic [WORD_WIDTH-1:0]                           out_data,
  input  logic                                            out_ready,
  output logic                                            busy,
  output logic                                            timeout_err,
  output logic [((NUM_REQ > 1) ? $clog2(NUM_REQ) : 1)-1:0] err_id
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CTR_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CTR_W-1:0] CTR_LAST = CTR_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [CTR_W-1:0] CTR_MAX  = {CTR_W{1'b1}};
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_REQ - 1);

  typedef enum logic {IDLE, GRANT} state_e;

  state_e                 state_q;
  logic [NUM_REQ-1:0]     grant_q;
  logic [IDX_W-1:0]       g_q;
  logic [IDX_W-1:0]       ptr_q;
  logic [IDX_W-1:0]       ptr_d;
  logic [CTR_W-1:0]       stall_ctr_q;
  logic                   busy_q;
  logic                   timeout_err_q;
  logic [IDX_W-1:0]       err_id_q;

  logic                   g_valid;
  logic                   g_last;
  logic [WORD_WIDTH-1:0]  g_data;
  logic                   xfer;
  logic                   pick_found;
  logic [IDX_W-1:0]       pick_idx;
  logic [NUM_REQ-1:0]     pick_onehot;

  function automatic logic [IDX_W-1:0] rr_index(input logic [IDX_W-1:0] base, input int offs);
    int j;
    j = int'(base) + offs;
    if (j >= NUM_REQ) j -= NUM_REQ;
    return IDX_W'(j);
  endfunction

  // Scan from the highest offset down so the lowest offset from ptr wins.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_valid[rr_index(ptr_q, k)]) begin
        pick_found = 1'b1;
        pick_idx   = rr_index(ptr_q, k);
      end
    end
  end

  always_comb begin
    pick_onehot = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      pick_onehot[i] = pick_found && (pick_idx == IDX_W'(i));
    end
  end

  always_comb begin
    g_valid = 1'b0;
    g_last  = 1'b0;
    g_data  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (g_q == IDX_W'(i)) begin
        g_valid = req_valid[i];
        g_last  = req_last[i];
        g_data  = req_data[i*WORD_WIDTH +: WORD_WIDTH];
      end
    end
  end

  // Word path is combinational; reset forces the handshake low so nothing moves.
  always_comb begin
    out_valid = 1'b0;
    out_data  = '0;
    req_ready = '0;
    if (state_q == GRANT && !rst) begin
      out_valid = g_valid;
      out_data  = g_data;
      for (int i = 0; i < NUM_REQ; i++) begin
        req_ready[i] = out_ready && (g_q == IDX_W'(i));
      end
    end
  end

  assign xfer  = out_valid && out_ready;
  assign ptr_d = (g_q == IDX_LAST) ? '0 : g_q + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      grant_q       <= '0;
      g_q           <= '0;
      ptr_q         <= '0;
      stall_ctr_q   <= '0;
      busy_q        <= 1'b0;
      timeout_err_q <= 1'b0;
      err_id_q      <= '0;
    end else begin
      timeout_err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (pick_found) begin
            state_q     <= GRANT;
            g_q         <= pick_idx;
            grant_q     <= pick_onehot;
            stall_ctr_q <= '0;
            busy_q      <= 1'b1;
          end
        end
        GRANT: begin
          if (xfer) begin
            stall_ctr_q <= '0;
            if (g_last) begin
              state_q <= IDLE;
              grant_q <= '0;
              busy_q  <= 1'b0;
              ptr_q   <= ptr_d;
            end
          end else if (!g_valid) begin
            // Backpressure with valid high holds the counter; only a silent source ages it.
            if (TIMEOUT_CYCLES != 0 && stall_ctr_q == CTR_LAST) begin
              state_q       <= IDLE;
              grant_q       <= '0;
              busy_q        <= 1'b0;
              ptr_q         <= ptr_d;
              stall_ctr_q   <= '0;
              timeout_err_q <= 1'b1;
              err_id_q      <= g_q;
            end else if (stall_ctr_q != CTR_MAX) begin
              stall_ctr_q <= stall_ctr_q + 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign grant       = grant_q;
  assign busy        = busy_q;
  assign timeout_err = timeout_err_q;
  assign err_id      = err_id_q;

endmodule

// File: tb/tb_lcd_tx_arbiter.sv
// tb/tb_lcd_tx_arbiter.sv - self-checking bench for lcd_tx_arbiter
// Scripted vector table, corner-case sequences and a randomized run against a reference model.
module tb_lcd_tx_arbiter;

  localparam int N  = 3;
  localparam int W  = 9;
  localparam int TO = 8;
  localparam logic [8:0] D0 = 9'h0A0;
  localparam logic [8:0] D1 = 9'h0B1;
  localparam logic [8:0] D2 = 9'h1C2;

  logic         clk = 1'b0;
  logic         rst;
  logic [2:0]   req_valid;
  logic [26:0]  req_data;
  logic [2:0]   req_last;
  logic [2:0]   req_ready;
  logic [2:0]   grant;
  logic         out_valid;
  logic [8:0]   out_data;
  logic         out_ready;
  logic         busy;
  logic         timeout_err;
  logic [1:0]   err_id;

  lcd_tx_arbiter #(.NUM_REQ(N), .WORD_WIDTH(W), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_data(req_data), .req_last(req_last), .req_ready(req_ready),
    .grant(grant), .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .busy(busy), .timeout_err(timeout_err), .err_id(err_id)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       rst;
    logic [2:0] v;
    logic [2:0] l;
    logic       rdy;
    logic [2:0] e_grant;
    logic       e_ov;
    logic [8:0] e_od;
    logic [2:0] e_rdy;
    logic       e_busy;
  } vec_t;

  vec_t vecs[21];

  function automatic vec_t mk(input logic r, input logic [2:0] v, input logic [2:0] l, input logic rdy,
                              input logic [2:0] eg, input logic eov, input logic [8:0] eod,
                              input logic [2:0] erdy, input logic eb);
    vec_t x;
    x.rst = r; x.v = v; x.l = l; x.rdy = rdy;
    x.e_grant = eg; x.e_ov = eov; x.e_od = eod; x.e_rdy = erdy; x.e_busy = eb;
    return x;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; req_valid = '0; req_last = '0; out_ready = 1'b1; req_data = {D2, D1, D0};
    step(); step();
    rst = 1'b0;
  endtask

  // Reference model state: owner -1 means no grant held.
  int         m_owner, m_ptr, m_stall, m_err;
  logic       m_terr;

  task automatic model_reset();
    m_owner = -1; m_ptr = 0; m_stall = 0; m_err = 0; m_terr = 1'b0;
  endtask

  function automatic logic [19:0] model_expect();
    logic [2:0] eg, erdy;
    logic       eov;
    logic [8:0] eod;
    eg = '0; erdy = '0; eov = 1'b0; eod = '0;
    if (m_owner >= 0) begin
      eg = 3'(1 << m_owner);
      if (!rst) begin
        eov = req_valid[m_owner];
        eod = req_data[m_owner*9 +: 9];
        if (out_ready) erdy = 3'(1 << m_owner);
      end
    end
    return {eg, eov, eod, erdy, (m_owner >= 0), m_terr, 2'(m_err)};
  endfunction

  task automatic model_advance();
    if (rst) begin
      model_reset();
    end else begin
      m_terr = 1'b0;
      if (m_owner < 0) begin
        for (int k = 0; k < N; k++) begin
          if (m_owner < 0 && req_valid[(m_ptr + k) % N]) begin
            m_owner = (m_ptr + k) % N;
            m_stall = 0;
          end
        end
      end else if (req_valid[m_owner] && out_ready) begin
        m_stall = 0;
        if (req_last[m_owner]) begin
          m_ptr = (m_owner + 1) % N;
          m_owner = -1;
        end
      end else if (!req_valid[m_owner]) begin
        m_stall++;
        if (m_stall == TO) begin
          m_terr = 1'b1;
          m_err = m_owner;
          m_ptr = (m_owner + 1) % N;
          m_owner = -1;
          m_stall = 0;
        end
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_time_limit");
    $fatal(1, "time limit");
  end

  initial begin
    logic [8:0] words[3];
    logic [8:0] got[$];
    logic [1:0] pat[4];
    int         idx, e_at, pulses, sleep[3];
    logic       adv, tmo_seen;
    logic [2:0] g_at, g_after;
    logic [1:0] id_at;

    vecs[0]  = mk(1, 3'b111, 3'b000, 1, 3'b000, 0, 9'h000, 3'b000, 0);
    vecs[1]  = mk(0, 3'b111, 3'b000, 1, 3'b000, 0, 9'h000, 3'b000, 0);
    vecs[2]  = mk(0, 3'b111, 3'b000, 1, 3'b001, 1, D0,     3'b001, 1);
    vecs[3]  = mk(0, 3'b111, 3'b001, 1, 3'b001, 1, D0,     3'b001, 1);
    vecs[4]  = mk(0, 3'b111, 3'b000, 1, 3'b000, 0, 9'h000, 3'b000, 0);
    vecs[5]  = mk(0, 3'b111, 3'b000, 1, 3'b010, 1, D1,     3'b010, 1);
    vecs[6]  = mk(0, 3'b111, 3'b010, 1, 3'b010, 1, D1,     3'b010, 1);
    vecs[7]  = mk(0, 3'b111, 3'b000, 1, 3'b000, 0, 9'h000, 3'b000, 0);
    vecs[8]  = mk(0, 3'b111, 3'b000, 1, 3'b100, 1, D2,     3'b100, 1);
    vecs[9]  = mk(0, 3'b111, 3'b100, 1, 3'b100, 1, D2,     3'b100, 1);
    vecs[10] = mk(0, 3'b111, 3'b000, 1, 3'b000, 0, 9'h000, 3'b000, 0);
    vecs[11] = mk(0, 3'b111, 3'b001, 0, 3'b001, 1, D0,     3'b000, 1);
    vecs[12] = mk(0, 3'b111, 3'b001, 1, 3'b001, 1, D0,     3'b001, 1);
    vecs[13] = mk(0, 3'b000, 3'b000, 1, 3'b000, 0, 9'h000, 3'b000, 0);
    vecs[14] = mk(0, 3'b100, 3'b000, 1, 3'b000, 0, 9'h000, 3'b000, 0);
    vecs[15] = mk(0, 3'b100, 3'b100, 1, 3'b100, 1, D2,     3'b100, 1);
    vecs[16] = mk(0, 3'b011, 3'b000, 1, 3'b000, 0, 9'h000, 3'b000, 0);
    vecs[17] = mk(0, 3'b010, 3'b001, 1, 3'b001, 0, D0,     3'b001, 1);
    vecs[18] = mk(0, 3'b011, 3'b001, 1, 3'b001, 1, D0,     3'b001, 1);
    vecs[19] = mk(0, 3'b011, 3'b000, 1, 3'b000, 0, 9'h000, 3'b000, 0);
    vecs[20] = mk(0, 3'b011, 3'b010, 1, 3'b010, 1, D1,     3'b010, 1);

    // Table: reset with all requesting, round robin, backpressure, single-word, last without valid.
    rst = 1'b1; req_valid = 3'b111; req_last = '0; out_ready = 1'b1; req_data = {D2, D1, D0};
    step(); step();
    for (int i = 0; i < 21; i++) begin
      rst = vecs[i].rst; req_valid = vecs[i].v; req_last = vecs[i].l; out_ready = vecs[i].rdy;
      #1;
      chk($sformatf("vec%0d_grant", i), 32'(grant), 32'(vecs[i].e_grant));
      chk($sformatf("vec%0d_out_valid", i), 32'(out_valid), 32'(vecs[i].e_ov));
      chk($sformatf("vec%0d_out_data", i), 32'(out_data), 32'(vecs[i].e_od));
      chk($sformatf("vec%0d_req_ready", i), 32'(req_ready), 32'(vecs[i].e_rdy));
      chk($sformatf("vec%0d_busy", i), 32'(busy), 32'(vecs[i].e_busy));
      chk($sformatf("vec%0d_timeout_err", i), 32'(timeout_err), 32'(0));
      step();
    end

    // Atomicity under backpressure.
    do_reset();
    words[0] = 9'h02C; words[1] = 9'h1FF; words[2] = 9'h1AA;
    pat[0] = 2'd1; pat[1] = 2'd0; pat[2] = 2'd0; pat[3] = 2'd1;
    idx = 0; tmo_seen = 1'b0; got.delete();
    for (int c = 0; c < 40; c++) begin
      req_valid = {1'b0, 1'b1, (idx < 3)};
      req_last  = {1'b0, 1'b1, (idx == 2)};
      req_data  = {D2, 9'h055, (idx < 3) ? words[idx] : 9'h000};
      out_ready = pat[c % 4][0];
      #1;
      if (out_valid && out_ready) got.push_back(out_data);
      if (timeout_err) tmo_seen = 1'b1;
      adv = req_ready[0] && req_valid[0];
      step();
      if (timeout_err) tmo_seen = 1'b1;
      if (adv) idx++;
    end
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("atom_word%0d", k), (k < got.size()) ? 32'(got[k]) : 32'hFFFF_FFFF,
          (k < 3) ? 32'(words[k]) : 32'h055);
    end
    chk("atom_no_timeout", 32'(tmo_seen), 32'(0));

    // Watchdog expiry on req2, then hand-over to req0.
    do_reset();
    req_valid = 3'b100; req_last = '0; out_ready = 1'b1;
    step();
    chk("wd_grant2", 32'(grant), 32'(3'b100));
    step();
    req_valid = 3'b001;
    e_at = -1; pulses = 0; g_at = 3'b111; g_after = 3'b111; id_at = 2'b00;
    for (int e = 1; e <= 14; e++) begin
      step();
      if (timeout_err) begin
        pulses++;
        if (e_at < 0) begin e_at = e; g_at = grant; id_at = err_id; end
      end
      if (e_at > 0 && e == e_at + 1) g_after = grant;
    end
    chk("wd_pulse_edge", 32'(e_at), 32'(8));
    chk("wd_pulse_len", 32'(pulses), 32'(1));
    chk("wd_err_id", 32'(id_at), 32'(2));
    chk("wd_grant_cleared", 32'(g_at), 32'(0));
    chk("wd_next_grant", 32'(g_after), 32'(3'b001));
    chk("wd_err_id_holds", 32'(err_id), 32'(2));

    // Last word arriving just before expiry completes normally.
    do_reset();
    req_valid = 3'b010; req_last = '0; out_ready = 1'b1;
    step();
    req_valid = 3'b000;
    tmo_seen = 1'b0;
    for (int k = 0; k < 7; k++) begin
      step();
      if (timeout_err) tmo_seen = 1'b1;
    end
    chk("exp_grant_held", 32'(grant), 32'(3'b010));
    req_valid = 3'b010; req_last = 3'b010;
    #1;
    chk("exp_ready", 32'(req_ready), 32'(3'b010));
    chk("exp_out_valid", 32'(out_valid), 32'(1));
    step();
    if (timeout_err) tmo_seen = 1'b1;
    chk("exp_no_timeout", 32'(tmo_seen), 32'(0));
    chk("exp_released", 32'({grant, busy}), 32'(0));

    // Reset in the middle of a five-word packet.
    do_reset();
    req_valid = 3'b011; req_last = '0; out_ready = 1'b1;
    step();
    for (int k = 0; k < 3; k++) begin
      req_data = {D2, D1, 9'(9'h100 + k)};
      #1;
      chk($sformatf("mid_xfer%0d", k), 32'({out_valid, req_ready}), 32'({1'b1, 3'b001}));
      step();
    end
    rst = 1'b1; req_data = {D2, D1, 9'h103};
    #1;
    chk("mid_rst_blocks", 32'({out_valid, req_ready}), 32'(0));
    step();
    chk("mid_rst_grant", 32'({grant, busy}), 32'(0));
    rst = 1'b0;
    step();
    chk("mid_regrant0", 32'(grant), 32'(3'b001));

    // Randomized run against the reference model.
    do_reset();
    model_reset();
    for (int i = 0; i < 3; i++) sleep[i] = 0;
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 199) == 0);
      for (int i = 0; i < 3; i++) begin
        if (sleep[i] > 0) begin
          req_valid[i] = 1'b0;
          sleep[i]--;
        end else begin
          req_valid[i] = ($urandom_range(0, 3) != 0);
          if ($urandom_range(0, 29) == 0) sleep[i] = $urandom_range(3, 14);
        end
        req_last[i] = ($urandom_range(0, 2) == 0);
        req_data[i*9 +: 9] = 9'($urandom);
      end
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      chk($sformatf("rand_cycle%0d", c),
          32'({grant, out_valid, out_data, req_ready, busy, timeout_err, err_id}),
          32'(model_expect()));
      model_advance();
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
